lcd_bus_arbiter: RTL and testbench

LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

---
 rtl/lcd_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_arbiter.sv
// -----------------------------------------------------------------------------
// lcd_bus_arbiter
//
// Purpose:
//    Shares one LCD controller command port between two requesters. A request
//    is accepted only while the arbiter is idle, the controller is not busy and
//    no acknowledge is being signalled. The winning command is latched and
//    strobed for one cycle. It is then held on the bus for a fixed hold-off
//    period before the owner is acknowledged and the bus is released.
//
// Configuration macro:
//    LCD_ARB_ROUND_ROBIN_EN - when defined, a tie goes to the requester that
//                             was not served last. When undefined, requester 0
//                             always wins a tie and no pointer exists.
//
// Parameters:
//    GAP_CYCLES - hold-off cycles after each issued command (2..4095)
//    CBITS      - width of the hold-off counter
//
// Ports:
//    clk              in   sole clock, rising edge
//    rst_n            in   asynchronous active-low reset
//    req0 / req1      in   requester N wants to send one command
//    cmd0 / cmd1      in   command {rs, rw, data[7:0]} from requester N
//    grant0 / grant1  out  requester N owns the LCD bus
//    ack0 / ack1      out  one-cycle pulse, requester N's command is complete
//    lcd_busy         in   LCD controller busy (initialisation)
//    lcd_enable       out  one-cycle command strobe to the controller
//    lcd_bus          out  command to the controller, same format as cmdN
// -----------------------------------------------------------------------------
module lcd_bus_arbiter #(
   parameter int GAP_CYCLES = 1024,
   parameter int CBITS      = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic       req1,
   input  logic [9:0] cmd0,
   input  logic [9:0] cmd1,
   output logic       grant0,
   output logic       grant1,
   output logic       ack0,
   output logic       ack1,
   input  logic       lcd_busy,
   output logic       lcd_enable,
   output logic [9:0] lcd_bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [CBITS-1:0] LAST_CNT = CBITS'(GAP_CYCLES - 1);
   localparam logic [CBITS-1:0] CNT_ONE  = {{(CBITS-1){1'b0}}, 1'b1};

   state_t           state_r;
   logic [CBITS-1:0] cnt_r;
   logic             sel_r;          // requester currently owning the bus
   logic             pick_valid_s;   // at least one request pending
   logic             pick_s;         // index of the requester that would win

`ifdef LCD_ARB_ROUND_ROBIN_EN
   logic             last_r;         // requester served most recently
`endif

   // Arbitration: choose which pending request would be accepted this cycle.
   always_comb begin
      pick_valid_s = 1'b0;
      pick_s       = 1'b0;
      if (req0 && req1) begin
         pick_valid_s = 1'b1;
`ifdef LCD_ARB_ROUND_ROBIN_EN
         pick_s       = ~last_r;
`else
         pick_s       = 1'b0;
`endif
      end else if (req0) begin
         pick_valid_s = 1'b1;
         pick_s       = 1'b0;
      end else if (req1) begin
         pick_valid_s = 1'b1;
         pick_s       = 1'b1;
      end else begin
         pick_valid_s = 1'b0;
         pick_s       = 1'b0;
      end
   end

   // Control FSM: accept, strobe, hold off, acknowledge; all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         cnt_r      <= {CBITS{1'b0}};
         sel_r      <= 1'b0;
         grant0     <= 1'b0;
         grant1     <= 1'b0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         lcd_enable <= 1'b0;
         lcd_bus    <= 10'h000;
`ifdef LCD_ARB_ROUND_ROBIN_EN
         last_r     <= 1'b1;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               ack0  <= 1'b0;
               ack1  <= 1'b0;
               cnt_r <= {CBITS{1'b0}};
               // The registered ack blocks sampling, so a requester that keeps
               // req high is seen again only in the cycle after its ack.
               if (!lcd_busy && !ack0 && !ack1 && pick_valid_s) begin
                  sel_r      <= pick_s;
                  grant0     <= ~pick_s;
                  grant1     <= pick_s;
                  lcd_enable <= 1'b1;
                  lcd_bus    <= pick_s ? cmd1 : cmd0;
                  state_r    <= ISSUE;
               end else begin
                  grant0     <= 1'b0;
                  grant1     <= 1'b0;
                  lcd_enable <= 1'b0;
                  lcd_bus    <= 10'h000;
                  state_r    <= IDLE;
               end
            end

            ISSUE: begin
               lcd_enable <= 1'b0;
               cnt_r      <= {CBITS{1'b0}};
               state_r    <= HOLD;
            end

            HOLD: begin
               // lcd_busy is deliberately not looked at here; the count alone
               // paces commands.
               if (cnt_r == LAST_CNT) begin
                  grant0  <= 1'b0;
                  grant1  <= 1'b0;
                  ack0    <= ~sel_r;
                  ack1    <= sel_r;
                  lcd_bus <= 10'h000;
                  cnt_r   <= {CBITS{1'b0}};
                  state_r <= IDLE;
`ifdef LCD_ARB_ROUND_ROBIN_EN
                  last_r  <= sel_r;
`endif
               end else begin
                  cnt_r   <= cnt_r + CNT_ONE;
                  state_r <= HOLD;
               end
            end

            default: begin
               state_r    <= IDLE;
               cnt_r      <= {CBITS{1'b0}};
               grant0     <= 1'b0;
               grant1     <= 1'b0;
               ack0       <= 1'b0;
               ack1       <= 1'b0;
               lcd_enable <= 1'b0;
               lcd_bus    <= 10'h000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lcd_bus_arbiter
//
// Directed self-checking bench for lcd_bus_arbiter with GAP_CYCLES = 8.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Cycle numbers inside each test count rising edges from the point named in
// the local comment. Timing expected throughout:
//    sample edge -> strobe cycle (grant, lcd_enable, lcd_bus valid)
//    strobe + 9  -> ack cycle (grant dropped, lcd_bus = 0)
//    ack + 2     -> next strobe for a requester that keeps req high
// -----------------------------------------------------------------------------
module tb_lcd_bus_arbiter;

   localparam int GAP = 8;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b1;
   logic       req0     = 1'b0;
   logic       req1     = 1'b0;
   logic [9:0] cmd0     = 10'h000;
   logic [9:0] cmd1     = 10'h000;
   logic       lcd_busy = 1'b0;
   logic       grant0;
   logic       grant1;
   logic       ack0;
   logic       ack1;
   logic       lcd_enable;
   logic [9:0] lcd_bus;

   int n_cmp     = 0;
   int n_bad     = 0;
   int excl_viol = 0;

   lcd_bus_arbiter #(
      .GAP_CYCLES (GAP),
      .CBITS      (12)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0       (req0),
      .req1       (req1),
      .cmd0       (cmd0),
      .cmd1       (cmd1),
      .grant0     (grant0),
      .grant1     (grant1),
      .ack0       (ack0),
      .ack1       (ack1),
      .lcd_busy   (lcd_busy),
      .lcd_enable (lcd_enable),
      .lcd_bus    (lcd_bus)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Records any cycle where both grants or both acks are high.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && ((grant0 === 1'b1 && grant1 === 1'b1) ||
                             (ack0 === 1'b1 && ack1 === 1'b1)))
         excl_viol++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Cycles until lcd_enable is seen, or -1 if the bound expires.
   task automatic wait_strobe(input int limit, output int cycles);
      bit found = 1'b0;
      cycles = -1;
      for (int i = 1; i <= limit; i++) begin
         if (!found) begin
            tick();
            if (lcd_enable === 1'b1) begin
               cycles = i;
               found  = 1'b1;
            end
         end
      end
   endtask

   // Cycles until any ack is seen, or -1 if the bound expires.
   task automatic wait_ack(input int limit, output int cycles);
      bit found = 1'b0;
      cycles = -1;
      for (int i = 1; i <= limit; i++) begin
         if (!found) begin
            tick();
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
               cycles = i;
               found  = 1'b1;
            end
         end
      end
   endtask

   task automatic test_reset();
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({grant0, grant1, ack0, ack1, lcd_enable, lcd_bus} !== 15'h0000) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h expected 0000",
                  {grant0, grant1, ack0, ack1, lcd_enable, lcd_bus});
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if ({grant0, grant1, ack0, ack1, lcd_enable, lcd_bus} !== 15'h0000) begin
         n_bad++;
         $display("FAIL idle_after_reset: got %h expected 0000",
                  {grant0, grant1, ack0, ack1, lcd_enable, lcd_bus});
      end
   endtask

   task automatic test_single();
      int         ack_at = -1;
      int         strobes = 0;
      int         hold_bad = 0;
      logic [10:0] at_ack = 11'h7FF;
      req0 = 1'b1;
      cmd0 = 10'h241;
      tick();
      n_cmp++;
      if ({grant0, grant1, lcd_enable, lcd_bus} !== {1'b1, 1'b0, 1'b1, 10'h241}) begin
         n_bad++;
         $display("FAIL single_issue: got g0=%b g1=%b en=%b bus=%h expected 1 0 1 241",
                  grant0, grant1, lcd_enable, lcd_bus);
      end
      req0 = 1'b0;
      // i counts cycles after the strobe cycle
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (lcd_enable === 1'b1) strobes++;
         if (ack0 === 1'b1 && ack_at < 0) begin
            ack_at = i;
            at_ack = {grant0, lcd_bus};
         end
         if (i < 9 && (lcd_bus !== 10'h241 || grant0 !== 1'b1)) hold_bad++;
      end
      n_cmp++;
      if (ack_at !== 9) begin
         n_bad++;
         $display("FAIL single_ack_latency: got %0d expected 9", ack_at);
      end
      n_cmp++;
      if (strobes !== 0 || hold_bad !== 0) begin
         n_bad++;
         $display("FAIL single_hold: got strobes=%0d bad_hold=%0d expected 0 0", strobes, hold_bad);
      end
      n_cmp++;
      if (at_ack !== 11'h000) begin
         n_bad++;
         $display("FAIL single_release: got grant/bus=%h expected 000", at_ack);
      end
   endtask

   task automatic test_busy();
      int strobes = 0;
      int c;
      lcd_busy = 1'b1;
      req1     = 1'b1;
      cmd1     = 10'h155;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (lcd_enable !== 1'b0) strobes++;
      end
      n_cmp++;
      if (strobes !== 0) begin
         n_bad++;
         $display("FAIL busy_blocks: got %0d strobes expected 0", strobes);
      end
      lcd_busy = 1'b0;
      tick();
      n_cmp++;
      if ({grant0, grant1, lcd_enable, lcd_bus} !== {1'b0, 1'b1, 1'b1, 10'h155}) begin
         n_bad++;
         $display("FAIL busy_release_strobe: got g0=%b g1=%b en=%b bus=%h expected 0 1 1 155",
                  grant0, grant1, lcd_enable, lcd_bus);
      end
      req1 = 1'b0;
      wait_ack(15, c);
      n_cmp++;
      if (c !== 9 || ack1 !== 1'b1 || ack0 !== 1'b0) begin
         n_bad++;
         $display("FAIL busy_ack1: got cycles=%0d ack0=%b ack1=%b expected 9 0 1", c, ack0, ack1);
      end
      tick();
   endtask

   task automatic test_priority();
      int c;
      int got[4];
`ifdef LCD_ARB_ROUND_ROBIN_EN
      int nstrobe = 4;
      int exp_o[4] = '{0, 1, 0, 1};
`else
      int nstrobe = 3;
      int exp_o[4] = '{0, 0, 0, 0};
`endif
      apply_reset();
      cmd0 = 10'h001;
      cmd1 = 10'h002;
      req0 = 1'b1;
      req1 = 1'b1;
      for (int k = 0; k < nstrobe; k++) begin
         wait_strobe(20, c);
         if (c < 0)
            got[k] = 9;
         else if (grant1 === 1'b1 && lcd_bus === 10'h002)
            got[k] = 1;
         else if (grant0 === 1'b1 && lcd_bus === 10'h001)
            got[k] = 0;
         else
            got[k] = 7;
      end
      req0 = 1'b0;
      req1 = 1'b0;
      for (int k = 0; k < nstrobe; k++) begin
         n_cmp++;
         if (got[k] !== exp_o[k]) begin
            n_bad++;
            $display("FAIL priority_order[%0d]: got requester %0d expected %0d", k, got[k], exp_o[k]);
         end
      end
      wait_ack(20, c);
      tick();
   endtask

   task automatic test_cmd_change();
      int ack_at = -1;
      int strobes = 0;
      int bad = 0;
      req0 = 1'b1;
      cmd0 = 10'h241;
      tick();
      n_cmp++;
      if (lcd_enable !== 1'b1 || lcd_bus !== 10'h241) begin
         n_bad++;
         $display("FAIL cmd_issue: got en=%b bus=%h expected 1 241", lcd_enable, lcd_bus);
      end
      req0 = 1'b0;
      repeat (3) tick();
      cmd0 = 10'h0FF;
      // i continues counting cycles after the strobe cycle
      for (int i = 4; i <= 12; i++) begin
         tick();
         if (lcd_enable === 1'b1) strobes++;
         if (ack0 === 1'b1 && ack_at < 0) ack_at = i;
         if (ack_at < 0 && lcd_bus !== 10'h241) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_bad++;
         $display("FAIL cmd_bus_stable: got %0d bad cycles expected 0", bad);
      end
      n_cmp++;
      if (strobes !== 0) begin
         n_bad++;
         $display("FAIL cmd_no_extra_strobe: got %0d expected 0", strobes);
      end
      n_cmp++;
      if (ack_at !== 9) begin
         n_bad++;
         $display("FAIL cmd_ack: got %0d expected 9", ack_at);
      end
      cmd0 = 10'h000;
   endtask

   task automatic test_reset_mid();
      int acks = 0;
      int c;
      req0 = 1'b1;
      cmd0 = 10'h241;
      tick();
      req0 = 1'b0;
      repeat (4) tick();   // hold counter now 3
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({grant0, grant1, ack0, ack1, lcd_enable, lcd_bus} !== 15'h0000) begin
         n_bad++;
         $display("FAIL async_reset_outputs: got %h expected 0000",
                  {grant0, grant1, ack0, ack1, lcd_enable, lcd_bus});
      end
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (ack0 === 1'b1 || ack1 === 1'b1 || lcd_enable === 1'b1) acks++;
      end
      n_cmp++;
      if (acks !== 0) begin
         n_bad++;
         $display("FAIL no_ack_after_reset: got %0d events expected 0", acks);
      end
      req0 = 1'b1;
      cmd0 = 10'h033;
      tick();
      n_cmp++;
      if ({grant0, lcd_enable, lcd_bus} !== {1'b1, 1'b1, 10'h033}) begin
         n_bad++;
         $display("FAIL fresh_issue: got g0=%b en=%b bus=%h expected 1 1 033",
                  grant0, lcd_enable, lcd_bus);
      end
      req0 = 1'b0;
      wait_ack(15, c);
      n_cmp++;
      if (c !== 9 || ack0 !== 1'b1) begin
         n_bad++;
         $display("FAIL fresh_ack: got cycles=%0d ack0=%b expected 9 1", c, ack0);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int s_n = 0;
      int a_n = 0;
      int s_t[4] = '{-100, -100, -100, -100};
      int a_t[4] = '{-100, -100, -100, -100};
      int c;
      cmd0 = 10'h241;
      req0 = 1'b1;
      // expected strobes at 1, 12, 23 and acks at 10, 21
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (lcd_enable === 1'b1) begin
            if (s_n < 4) s_t[s_n] = i;
            s_n++;
         end
         if (ack0 === 1'b1) begin
            if (a_n < 4) a_t[a_n] = i;
            a_n++;
         end
      end
      req0 = 1'b0;
      n_cmp++;
      if (s_n !== 3 || a_n !== 2) begin
         n_bad++;
         $display("FAIL b2b_counts: got strobes=%0d acks=%0d expected 3 2", s_n, a_n);
      end
      n_cmp++;
      if (s_t[1] - a_t[0] !== 2) begin
         n_bad++;
         $display("FAIL b2b_ack_to_strobe: got %0d expected 2", s_t[1] - a_t[0]);
      end
      n_cmp++;
      if (s_t[1] - s_t[0] !== 11 || s_t[2] - s_t[1] !== 11) begin
         n_bad++;
         $display("FAIL b2b_spacing: got %0d %0d expected 11 11", s_t[1] - s_t[0], s_t[2] - s_t[1]);
      end
      wait_ack(20, c);
      n_cmp++;
      if (c < 0) begin
         n_bad++;
         $display("FAIL b2b_drain: got timeout expected final ack");
      end
      tick();
   endtask

   task automatic test_exclusive();
      n_cmp++;
      if (excl_viol !== 0) begin
         n_bad++;
         $display("FAIL mutual_exclusion: got %0d violating cycles expected 0", excl_viol);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_busy();
      test_priority();
      test_cmd_change();
      test_reset_mid();
      test_back_to_back();
      test_exclusive();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
